// File: rtl/mem_responder.sv
// Unified instruction/data memory slave with fixed wait-state latency and one-cycle completion pulse.
// Optional feature: define MEM_ALIGN_CHECK_EN to flag misaligned accesses via mem_err.
module mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        mem_ready,
  output logic        mem_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              wr_q, wr_d;
  logic              err_q, err_d;
  logic [IDX_W-1:0]  addr_idx;
  logic              misalign;
  logic [31:0]       mem [DEPTH_WORDS];

  // Upper address bits wrap away; byte-offset bits only matter for the alignment check.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:IDX_W+2], addr[1:0]};

  assign addr_idx = addr[IDX_W+1:2];

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = (addr[1:0] != 2'b00);
  assign mem_err  = (state_q == RESP) && err_q;
`else
  assign misalign = 1'b0;
  assign mem_err  = 1'b0;
`endif

  assign mem_ready = (state_q == RESP);
  assign rdata     = rdata_q;

  // rdata is loaded on the edge entering RESP so it is valid during the ready pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (MemRead || MemWrite) begin
          idx_d   = addr_idx;
          wdata_d = wdata;
          wr_d    = MemWrite;
          err_d   = misalign;
          if (LATENCY == 0) begin
            state_d = RESP;
            if (!MemWrite && !misalign) rdata_d = mem[addr_idx];
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          if (!wr_q && !err_q) rdata_d = mem[idx_q];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

  // Array is not reset; an async reset during RESP leaves IDLE before the commit edge.
  always_ff @(posedge clk) begin
    if ((state_q == RESP) && wr_q && !err_q) mem[idx_q] <= wdata_q;
  end

endmodule
